// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: trellis size, state encoding, decision-bit
// indices and the survivor-memory payload.
package viterbi_pkg;

    localparam int unsigned NUM_STATES   = 4;
    localparam int unsigned DEF_PM_WIDTH = 8;
    localparam int unsigned STATE_W      = 2;

    typedef enum logic [STATE_W-1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_e;

    localparam int unsigned DEC_S0 = 0;
    localparam int unsigned DEC_S1 = 1;
    localparam int unsigned DEC_S2 = 2;
    localparam int unsigned DEC_S3 = 3;

    typedef struct packed {
        logic [NUM_STATES-1:0] dec_bits;
        state_e                best_state;
        logic                  norm;
    } surv_payload_t;

endpackage

// File: rtl/pmu_if.sv
// PMU bus: ACSU-side metrics/decisions in, metrics back and survivor-memory handshake out.
// PMU_NORM_CNT_EN adds norm_cnt_o.
interface pmu_if #(
    parameter int unsigned PM_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 valid_i;
    logic                 ready_o;
    logic [PM_WIDTH-1:0]  pm_s0_i;
    logic [PM_WIDTH-1:0]  pm_s1_i;
    logic [PM_WIDTH-1:0]  pm_s2_i;
    logic [PM_WIDTH-1:0]  pm_s3_i;
    logic [3:0]           dec_bits_i;
    logic [PM_WIDTH-1:0]  pm_s0_o;
    logic [PM_WIDTH-1:0]  pm_s1_o;
    logic [PM_WIDTH-1:0]  pm_s2_o;
    logic [PM_WIDTH-1:0]  pm_s3_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [3:0]           dec_bits_o;
    logic [1:0]           best_state_o;
    logic                 norm_o;
    logic [CNT_WIDTH-1:0] sym_cnt_o;
`ifdef PMU_NORM_CNT_EN
    logic [7:0]           norm_cnt_o;
`endif

    modport slave (
        input  valid_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i, dec_bits_i, ready_i,
        output ready_o, pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o, valid_o,
               dec_bits_o, best_state_o, norm_o, sym_cnt_o
`ifdef PMU_NORM_CNT_EN
        , output norm_cnt_o
`endif
    );

    modport master (
        output valid_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i, dec_bits_i, ready_i,
        input  ready_o, pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o, valid_o,
               dec_bits_o, best_state_o, norm_o, sym_cnt_o
`ifdef PMU_NORM_CNT_EN
        , input norm_cnt_o
`endif
    );

endinterface

// File: rtl/pm_min4.sv
// Combinational minimum and argmin over the four path metrics; lowest index wins ties.
module pm_min4
    import viterbi_pkg::*;
#(
    parameter int unsigned W = DEF_PM_WIDTH
) (
    input  logic [NUM_STATES-1:0][W-1:0] pm_i,
    output logic [W-1:0]                 min_c,
    output logic [STATE_W-1:0]           arg_c
);

    logic [W-1:0] m01;
    logic [W-1:0] m23;
    logic         a01;
    logic         a23;

    // Pairwise tree; strict '<' keeps the lower index whenever metrics are equal.
    always_comb begin
        m01   = pm_i[0];
        a01   = 1'b0;
        m23   = pm_i[2];
        a23   = 1'b0;
        min_c = '0;
        arg_c = '0;
        if (pm_i[1] < pm_i[0]) begin
            m01 = pm_i[1];
            a01 = 1'b1;
        end
        if (pm_i[3] < pm_i[2]) begin
            m23 = pm_i[3];
            a23 = 1'b1;
        end
        if (m23 < m01) begin
            min_c = m23;
            arg_c = {1'b1, a23};
        end else begin
            min_c = m01;
            arg_c = {1'b0, a01};
        end
    end

endmodule

// File: rtl/pmu.sv
// Path Metric Unit: registers and normalizes ACSU metrics, forwards decisions and best
// state to survivor memory. PMU_NORM_CNT_EN adds a saturating normalization counter.
module pmu
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_WIDTH    = DEF_PM_WIDTH,
    parameter int unsigned NORM_THRESH = 128,
    parameter int unsigned INIT_MAX    = 255,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    pmu_if.slave bus
);

    logic [NUM_STATES-1:0][PM_WIDTH-1:0] pm_in;
    logic [NUM_STATES-1:0][PM_WIDTH-1:0] pm_q;
    logic [PM_WIDTH-1:0]                 pm_min;
    logic [STATE_W-1:0]                  pm_arg;
    logic                                norm;
    logic                                accept;
    logic                                valid_q;
    surv_payload_t                       pay_q;
    logic [CNT_WIDTH-1:0]                sym_cnt_q;

    assign pm_in = {bus.pm_s3_i, bus.pm_s2_i, bus.pm_s1_i, bus.pm_s0_i};

    pm_min4 #(.W(PM_WIDTH)) u_min4 (
        .pm_i  (pm_in),
        .min_c (pm_min),
        .arg_c (pm_arg)
    );

    assign norm        = (pm_min >= PM_WIDTH'(NORM_THRESH));
    assign bus.ready_o = !valid_q || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o && !start_i;

    // Frame start behaves exactly like reset, overriding any handshake activity.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || start_i) begin
            pm_q[0] <= '0;
            for (int k = 1; k < NUM_STATES; k++) begin
                pm_q[k] <= PM_WIDTH'(INIT_MAX);
            end
            valid_q   <= 1'b0;
            pay_q     <= '0;
            sym_cnt_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_STATES; k++) begin
                pm_q[k] <= pm_in[k] - (norm ? pm_min : '0);
            end
            valid_q   <= 1'b1;
            pay_q     <= '{dec_bits: bus.dec_bits_i, best_state: state_e'(pm_arg), norm: norm};
            sym_cnt_q <= sym_cnt_q + CNT_WIDTH'(1);
        end else if (valid_q && bus.ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.pm_s0_o      = pm_q[0];
    assign bus.pm_s1_o      = pm_q[1];
    assign bus.pm_s2_o      = pm_q[2];
    assign bus.pm_s3_o      = pm_q[3];
    assign bus.valid_o      = valid_q;
    assign bus.dec_bits_o   = pay_q.dec_bits;
    assign bus.best_state_o = pay_q.best_state;
    assign bus.norm_o       = pay_q.norm;
    assign bus.sym_cnt_o    = sym_cnt_q;

`ifdef PMU_NORM_CNT_EN
    logic [7:0] norm_cnt_q;

    // Saturating count of accepted symbols that needed normalization.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || start_i) begin
            norm_cnt_q <= '0;
        end else if (accept && norm && (norm_cnt_q != 8'hFF)) begin
            norm_cnt_q <= norm_cnt_q + 8'd1;
        end
    end

    assign bus.norm_cnt_o = norm_cnt_q;
`endif

endmodule

// File: tb/tb_pmu.sv
// Self-checking bench for pmu: directed scenarios plus randomized traffic against a
// behavioural model of the metric/handshake rules.
module tb_pmu;
    import viterbi_pkg::*;

    logic clk;
    logic rst_n;
    logic start;

    pmu_if bus ();

    pmu dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .bus     (bus)
    );

    int n_vec;
    int n_err;

    int exp_pm [4];
    bit exp_valid;
    int exp_dec;
    int exp_best;
    bit exp_norm;
    int exp_cnt;
    int exp_ncnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pm_out(input int k);
        case (k)
            0:       return bus.pm_s0_o;
            1:       return bus.pm_s1_o;
            2:       return bus.pm_s2_o;
            default: return bus.pm_s3_o;
        endcase
    endfunction

    task automatic set_in(input bit v, input int p0, input int p1, input int p2, input int p3,
                          input int dec, input bit rdy);
        bus.valid_i    = v;
        bus.pm_s0_i    = 8'(p0);
        bus.pm_s1_i    = 8'(p1);
        bus.pm_s2_i    = 8'(p2);
        bus.pm_s3_i    = 8'(p3);
        bus.dec_bits_i = 4'(dec);
        bus.ready_i    = rdy;
    endtask

    task automatic rand_in(input bit v, input bit rdy);
        int lo;
        int p [4];
        lo = int'($urandom_range(0, 255));
        for (int k = 0; k < 4; k++) p[k] = lo + int'($urandom_range(0, 255 - lo));
        if ($urandom_range(0, 3) == 0) p[$urandom_range(0, 3)] = p[$urandom_range(0, 3)];
        if ($urandom_range(0, 7) == 0) p[$urandom_range(0, 3)] = 255;
        set_in(v, p[0], p[1], p[2], p[3], int'($urandom_range(0, 15)), rdy);
    endtask

    task automatic model_reset();
        exp_pm    = '{0, 255, 255, 255};
        exp_valid = 1'b0;
        exp_dec   = 0;
        exp_best  = 0;
        exp_norm  = 1'b0;
        exp_cnt   = 0;
        exp_ncnt  = 0;
    endtask

    // Next-state of the observable outputs from the current inputs, evaluated before the edge.
    task automatic model_step();
        int in_pm [4];
        int mn;
        int arg;
        bit nrm;
        in_pm = '{int'(bus.pm_s0_i), int'(bus.pm_s1_i), int'(bus.pm_s2_i), int'(bus.pm_s3_i)};
        if (!rst_n || start) begin
            model_reset();
        end else if (bus.valid_i && (!exp_valid || bus.ready_i)) begin
            mn  = 256;
            arg = 0;
            for (int k = 0; k < 4; k++) begin
                if (in_pm[k] < mn) begin
                    mn  = in_pm[k];
                    arg = k;
                end
            end
            nrm = (mn >= 128);
            for (int k = 0; k < 4; k++) exp_pm[k] = in_pm[k] - (nrm ? mn : 0);
            exp_dec   = int'(bus.dec_bits_i);
            exp_best  = arg;
            exp_norm  = nrm;
            exp_valid = 1'b1;
            exp_cnt   = (exp_cnt + 1) % 65536;
            if (nrm && exp_ncnt < 255) exp_ncnt++;
        end else if (exp_valid && bus.ready_i) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("ready_o", 32'(bus.ready_o), 32'(!exp_valid || bus.ready_i));
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("pm_s%0d_o", k), 32'(pm_out(k)), 32'(exp_pm[k]));
        check("valid_o", 32'(bus.valid_o), 32'(exp_valid));
        check("dec_bits_o", 32'(bus.dec_bits_o), 32'(exp_dec));
        check("best_state_o", 32'(bus.best_state_o), 32'(exp_best));
        check("norm_o", 32'(bus.norm_o), 32'(exp_norm));
        check("sym_cnt_o", 32'(bus.sym_cnt_o), 32'(exp_cnt));
`ifdef PMU_NORM_CNT_EN
        check("norm_cnt_o", 32'(bus.norm_cnt_o), 32'(exp_ncnt));
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        tick();

        // Reset release
        rst_n = 1'b1;
        tick();
        check("t1_pm0", 32'(bus.pm_s0_o), 32'd0);
        check("t1_pm3", 32'(bus.pm_s3_o), 32'd255);
        check("t1_valid", 32'(bus.valid_o), 32'd0);
        check("t1_cnt", 32'(bus.sym_cnt_o), 32'd0);
        check("t1_ready", 32'(bus.ready_o), 32'd1);

        // Plain accept, no normalization
        set_in(1, 3, 5, 4, 6, 4'b1010, 1);
        tick();
        check("t2_pm1", 32'(bus.pm_s1_o), 32'd5);
        check("t2_pm2", 32'(bus.pm_s2_o), 32'd4);
        check("t2_dec", 32'(bus.dec_bits_o), 32'hA);
        check("t2_best", 32'(bus.best_state_o), 32'(S0));
        check("t2_norm", 32'(bus.norm_o), 32'd0);
        check("t2_cnt", 32'(bus.sym_cnt_o), 32'd1);

        // Normalization including a saturated metric
        set_in(1, 130, 128, 200, 255, 4'b0101, 1);
        tick();
        check("t3_pm0", 32'(bus.pm_s0_o), 32'd2);
        check("t3_pm1", 32'(bus.pm_s1_o), 32'd0);
        check("t3_pm2", 32'(bus.pm_s2_o), 32'd72);
        check("t3_pm3", 32'(bus.pm_s3_o), 32'd127);
        check("t3_best", 32'(bus.best_state_o), 32'(S1));
        check("t3_norm", 32'(bus.norm_o), 32'd1);
`ifdef PMU_NORM_CNT_EN
        check("t3_ncnt", 32'(bus.norm_cnt_o), 32'd1);
`endif

        // Tie resolves to lowest index, then downstream stall
        set_in(1, 9, 7, 7, 8, 4'b0011, 1);
        tick();
        check("t4_best", 32'(bus.best_state_o), 32'(S1));
        set_in(1, 20, 30, 40, 50, 4'b1111, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_ready", 32'(bus.ready_o), 32'd0);
            check("t4_cnt", 32'(bus.sym_cnt_o), 32'd3);
            check("t4_pm0", 32'(bus.pm_s0_o), 32'd9);
            check("t4_dec", 32'(bus.dec_bits_o), 32'h3);
        end

        // Start while a symbol is pending and another is offered
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_pm0", 32'(bus.pm_s0_o), 32'd0);
        check("t5_pm1", 32'(bus.pm_s1_o), 32'd255);
        check("t5_valid", 32'(bus.valid_o), 32'd0);
        check("t5_cnt", 32'(bus.sym_cnt_o), 32'd0);

        // Randomized traffic with occasional start and reset
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            start = ($urandom_range(0, 49) == 0);
            rand_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;

        // Counter wrap after 2^16 back-to-back symbols
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            rand_in(1, 1);
            tick();
        end
        check("t6_wrap", 32'(bus.sym_cnt_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            rand_in(1, 1);
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("t6_rst_pm0", 32'(bus.pm_s0_o), 32'd0);
        check("t6_rst_pm2", 32'(bus.pm_s2_o), 32'd255);
        check("t6_rst_valid", 32'(bus.valid_o), 32'd0);
        check("t6_rst_cnt", 32'(bus.sym_cnt_o), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
